// File: rtl/mio_bus_ctrl.sv
// Registered CPU data-port controller: latches one request, decodes RAM or
// peripheral slot, waits for ready/timeout and returns a one-cycle response.
module mio_bus_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int RAM_AW  = 10,
  parameter int NSLV    = 4,
  parameter int RAM_LAT = 1,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_ready,
  output logic                   cpu_err,
  output logic [RAM_AW-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_wdata,
  output logic                   ram_we,
  input  logic [DATA_W-1:0]      ram_rdata,
  output logic [NSLV-1:0]        per_sel,
  output logic                   per_we,
  output logic [ADDR_W-1:0]      per_addr,
  output logic [DATA_W-1:0]      per_wdata,
  input  logic [NSLV*DATA_W-1:0] per_rdata,
  input  logic [NSLV-1:0]        per_ready
);

  localparam int MAXC = (TIMEOUT > RAM_LAT) ? TIMEOUT : RAM_LAT;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic                we_q;
  logic                is_ram_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ready_q;
  logic                err_q;
  logic                ram_we_q;
  logic [NSLV-1:0]     sel_q;
  logic                per_we_q;

  logic [NSLV-1:0]     hit;
  logic [DATA_W-1:0]   slot_rd;
  logic                slot_rdy;

  // Slot k owns top nibble 4'hF-k; anything else falls through to RAM.
  always_comb begin
    hit = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (cpu_addr[ADDR_W-1 -: 4] == 4'(15 - k)) hit[k] = 1'b1;
    end
  end

  always_comb begin
    slot_rd = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (sel_q[k]) slot_rd = slot_rd | per_rdata[k*DATA_W +: DATA_W];
    end
    slot_rdy = |(sel_q & per_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      is_ram_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      ram_we_q <= 1'b0;
      sel_q    <= '0;
      per_we_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          rdata_q <= '0;
          if (cpu_req) begin
            we_q     <= cpu_we;
            addr_q   <= cpu_addr;
            wdata_q  <= cpu_wdata;
            is_ram_q <= ~|hit;
            sel_q    <= hit;
            per_we_q <= cpu_we & |hit;
            ram_we_q <= cpu_we & ~|hit;
            cnt_q    <= '0;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          ram_we_q <= 1'b0;
          if (is_ram_q) begin
            if (cnt_q == CW'(RAM_LAT - 1)) begin
              rdata_q <= we_q ? '0 : ram_rdata;
              ready_q <= 1'b1;
              state_q <= RESP;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else if (slot_rdy) begin
            // Ready beats a timeout landing in the same cycle.
            rdata_q  <= we_q ? '0 : slot_rd;
            ready_q  <= 1'b1;
            sel_q    <= '0;
            per_we_q <= 1'b0;
            state_q  <= RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rdata_q  <= '0;
            ready_q  <= 1'b1;
            err_q    <= 1'b1;
            sel_q    <= '0;
            per_we_q <= 1'b0;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          rdata_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          sel_q    <= '0;
          per_we_q <= 1'b0;
          ram_we_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign cpu_err   = err_q;
  assign ram_addr  = addr_q[RAM_AW+1:2];
  assign ram_wdata = wdata_q;
  assign ram_we    = ram_we_q;
  assign per_sel   = sel_q;
  assign per_we    = per_we_q;
  assign per_addr  = addr_q;
  assign per_wdata = wdata_q;

endmodule
